// File: rtl/pcie_gen3_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pcie_gen3_pkg : shared type codes, FSM states and buffer entry format
// Rev 1.0
// ----------------------------------------------------------------------------
package pcie_gen3_pkg;

  localparam logic [5:0] DATA      = 6'b100000;
  localparam logic [5:0] TLPSTART  = 6'b010000;
  localparam logic [5:0] TLPEND    = 6'b001000;
  localparam logic [5:0] DLLPEND   = 6'b000100;
  localparam logic [5:0] DLLPSTART = 6'b000010;
  localparam logic [5:0] TLPEDB    = 6'b000001;
  localparam logic [5:0] NONE      = 6'b000000;

  localparam int ENTRY_W = 11;
  localparam int CNT_W   = 13;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_IN_TLP  = 2'd1,
    ST_IN_DLLP = 2'd2
  } state_t;

  typedef struct packed {
    logic       dllp;
    logic       sop;
    logic       eop;
    logic [7:0] data;
  } entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/gen3_pkt_ram.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gen3_pkt_ram : simple dual-port packet store, one write port, registered read
// Rev 1.0
// ----------------------------------------------------------------------------
module gen3_pkt_ram #(
  parameter  int DEPTH = 2048,
  parameter  int WIDTH = 11,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [WIDTH-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[i_raddr];
    end
  end

  assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/gen3_packet_extractor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// gen3_packet_extractor : assembles classified Gen3 bytes into whole TLP/DLLP packets
// Rev 1.0
// ----------------------------------------------------------------------------
module gen3_packet_extractor
  import pcie_gen3_pkg::*;
#(
  parameter int DEPTH      = 2048,
  parameter int DLLP_BYTES = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       valid_in,
  input  logic [7:0] data_in,
  input  logic [5:0] type_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_sop,
  output logic       out_eop,
  output logic       out_dllp,
  output logic       pkt_drop,
  output logic       err_unexp
);

  localparam int              AW         = $clog2(DEPTH);
  localparam logic [AW:0]     c_DEPTH    = (AW+1)'(DEPTH);
  localparam logic [AW:0]     c_ONE      = (AW+1)'(1);
  localparam logic [CNT_W-1:0] c_DLLP_LEN = CNT_W'(DLLP_BYTES);

  state_t           r_state, w_state_nxt;
  logic [AW:0]      r_rptr, r_wptr_commit, r_wptr_work;
  logic             r_hold_vld, r_first, r_ovf;
  logic [7:0]       r_hold_data;
  logic [CNT_W-1:0] r_cnt;
  logic             r_drop, r_err, r_out_valid;

  logic [AW:0]      w_work_nxt, w_commit_nxt, w_rptr_nxt;
  logic             w_hold_vld_nxt, w_first_nxt, w_ovf_nxt, w_drop, w_err, w_we;
  logic [7:0]       w_hold_data_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  entry_t           w_wentry, w_rd;
  logic             w_hs, w_full;
  logic             w_data, w_start, w_tlpend, w_dllpend, w_tlpedb;
  logic             w_match_end, w_wrong_end, w_good_end;

  assign w_data    = valid_in && (type_in == DATA);
  assign w_start   = valid_in && ((type_in == TLPSTART) || (type_in == DLLPSTART));
  assign w_tlpend  = valid_in && (type_in == TLPEND);
  assign w_dllpend = valid_in && (type_in == DLLPEND);
  assign w_tlpedb  = valid_in && (type_in == TLPEDB);

  // Occupancy is measured against the consumer's pointer so a stalled output still counts
  assign w_full = (r_wptr_work - r_rptr) == c_DEPTH;

  assign w_match_end = ((r_state == ST_IN_TLP)  && w_tlpend) ||
                       ((r_state == ST_IN_DLLP) && w_dllpend);
  assign w_wrong_end = ((r_state == ST_IN_TLP)  && w_dllpend) ||
                       ((r_state == ST_IN_DLLP) && (w_tlpend || w_tlpedb));
  assign w_good_end  = w_match_end && !r_ovf && (r_cnt != '0) && !w_full &&
                       ((r_state == ST_IN_TLP) || (r_cnt == c_DLLP_LEN));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_we            = 1'b0;
    w_wentry.dllp   = (r_state == ST_IN_DLLP);
    w_wentry.sop    = r_first;
    w_wentry.eop    = 1'b0;
    w_wentry.data   = r_hold_data;
    w_work_nxt      = r_wptr_work;
    w_commit_nxt    = r_wptr_commit;
    w_hold_vld_nxt  = r_hold_vld;
    w_hold_data_nxt = r_hold_data;
    w_first_nxt     = r_first;
    w_cnt_nxt       = r_cnt;
    w_ovf_nxt       = r_ovf;
    w_drop          = 1'b0;
    w_err           = 1'b0;

    if (w_start) begin
      // A start inside a packet aborts it; the rewind is a no-op from IDLE
      if (r_state != ST_IDLE) begin
        w_drop = 1'b1;
        w_err  = 1'b1;
      end
      w_work_nxt     = r_wptr_commit;
      w_hold_vld_nxt = 1'b0;
      w_first_nxt    = 1'b1;
      w_cnt_nxt      = '0;
      w_ovf_nxt      = 1'b0;
      w_state_nxt    = (type_in == TLPSTART) ? ST_IN_TLP : ST_IN_DLLP;
    end else if (r_state == ST_IDLE) begin
      w_err = w_data || w_tlpend || w_dllpend || w_tlpedb;
    end else if (w_data) begin
      if (r_hold_vld) begin
        if (w_full) begin
          w_ovf_nxt = 1'b1;
        end else begin
          w_we        = 1'b1;
          w_work_nxt  = r_wptr_work + c_ONE;
          w_first_nxt = 1'b0;
        end
      end
      w_hold_vld_nxt  = 1'b1;
      w_hold_data_nxt = data_in;
      w_cnt_nxt       = sat_inc(r_cnt);
    end else if (w_tlpend || w_dllpend || w_tlpedb) begin
      w_hold_vld_nxt = 1'b0;
      w_state_nxt    = ST_IDLE;
      if (w_good_end) begin
        w_we          = 1'b1;
        w_wentry.eop  = 1'b1;
        w_work_nxt    = r_wptr_work + c_ONE;
        w_commit_nxt  = r_wptr_work + c_ONE;
      end else begin
        w_drop     = 1'b1;
        w_err      = w_wrong_end;
        w_work_nxt = r_wptr_commit;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wptr_work   <= '0;
      r_wptr_commit <= '0;
      r_hold_vld    <= 1'b0;
      r_hold_data   <= '0;
      r_first       <= 1'b0;
      r_cnt         <= '0;
      r_ovf         <= 1'b0;
      r_drop        <= 1'b0;
      r_err         <= 1'b0;
    end else begin
      r_wptr_work   <= w_work_nxt;
      r_wptr_commit <= w_commit_nxt;
      r_hold_vld    <= w_hold_vld_nxt;
      r_hold_data   <= w_hold_data_nxt;
      r_first       <= w_first_nxt;
      r_cnt         <= w_cnt_nxt;
      r_ovf         <= w_ovf_nxt;
      r_drop        <= w_drop;
      r_err         <= w_err;
    end
  end

  // The RAM always reads the entry that will be on the outputs next cycle
  assign w_hs       = r_out_valid && out_ready;
  assign w_rptr_nxt = r_rptr + {{AW{1'b0}}, w_hs};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rptr      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_rptr      <= w_rptr_nxt;
      r_out_valid <= (w_rptr_nxt != r_wptr_commit);
    end
  end

  gen3_pkt_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_ram (
    .clk     (clk),
    .rst     (rst),
    .i_we    (w_we),
    .i_waddr (r_wptr_work[AW-1:0]),
    .i_wdata (w_wentry),
    .i_raddr (w_rptr_nxt[AW-1:0]),
    .o_rdata (w_rd)
  );

  assign out_valid = r_out_valid;
  assign out_data  = r_out_valid ? w_rd.data : 8'h00;
  assign out_sop   = r_out_valid && w_rd.sop;
  assign out_eop   = r_out_valid && w_rd.eop;
  assign out_dllp  = r_out_valid && w_rd.dllp;
  assign pkt_drop  = r_drop;
  assign err_unexp = r_err;

endmodule
`default_nettype wire

// File: tb/tb_gen3_packet_extractor.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_gen3_packet_extractor : randomized and directed bench with packet-level model
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_gen3_packet_extractor;

  localparam int TDEPTH = 16;
  localparam int TDLLP  = 8;
  localparam logic [5:0] TY_DATA = 6'b100000, TY_TS = 6'b010000, TY_TE = 6'b001000;
  localparam logic [5:0] TY_DE = 6'b000100, TY_DS = 6'b000010, TY_EDB = 6'b000001;
  localparam logic [5:0] TY_NONE = 6'b000000;

  logic       clk, rst, valid_in, out_ready, out_valid;
  logic [7:0] data_in, out_data;
  logic [5:0] type_in;
  logic       out_sop, out_eop, out_dllp, pkt_drop, err_unexp;

  gen3_packet_extractor #(.DEPTH(TDEPTH), .DLLP_BYTES(TDLLP)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .type_in(type_in),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sop(out_sop),
    .out_eop(out_eop), .out_dllp(out_dllp), .pkt_drop(pkt_drop), .err_unexp(err_unexp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic timeout_fail(input string nm);
    n_tests++;
    n_fail++;
    $display("FAIL %s: wait bound expired (t=%0t)", nm, $time);
  endtask

  function automatic logic [10:0] mk(input bit dl, input bit s, input bit e, input logic [7:0] b);
    return {dl, s, e, b};
  endfunction

  // Model: a packet is a list of received bytes; it is released whole on a good end
  typedef struct { logic [10:0] e; int vis; } qe_t;
  qe_t        mq[$];
  logic [7:0] m_bytes[$];
  int         m_state, m_written, m_cnt, cyc;
  bit         m_ovf, m_match, m_d, m_e, m_ev, mdl_on, exp_drop, exp_err, c_ev;

  task automatic m_try();
    if (mq.size() + m_written >= TDEPTH) m_ovf = 1;
    else m_written++;
  endtask

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      mq.delete(); m_bytes.delete();
      m_state = 0; m_written = 0; m_cnt = 0; m_ovf = 0;
      exp_drop = 0; exp_err = 0; mdl_on = 1;
    end else begin
      m_ev = (mq.size() > 0) && (mq[0].vis <= cyc - 1);
      m_d = 0; m_e = 0;
      if (valid_in) begin
        if (type_in == TY_TS || type_in == TY_DS) begin
          if (m_state != 0) begin m_d = 1; m_e = 1; end
          m_state = (type_in == TY_DS) ? 2 : 1;
          m_bytes.delete(); m_written = 0; m_ovf = 0; m_cnt = 0;
        end else if (type_in == TY_DATA) begin
          if (m_state == 0) m_e = 1;
          else begin
            if (m_cnt > 0) m_try();
            m_bytes.push_back(data_in);
            if (m_cnt < 8191) m_cnt++;
          end
        end else if (type_in == TY_TE || type_in == TY_DE || type_in == TY_EDB) begin
          if (m_state == 0) m_e = 1;
          else begin
            m_match = (m_state == 1 && type_in == TY_TE) || (m_state == 2 && type_in == TY_DE);
            if (m_match && m_cnt > 0) m_try();
            if (m_match && m_cnt > 0 && !m_ovf && (m_state == 1 || m_cnt == TDLLP)) begin
              for (int i = 0; i < m_bytes.size(); i++)
                mq.push_back('{e: mk(m_state == 2, i == 0, i == m_bytes.size() - 1, m_bytes[i]),
                               vis: cyc + 1});
            end else begin
              m_d = 1;
              m_e = !m_match && !(m_state == 1 && type_in == TY_EDB);
            end
            m_state = 0;
          end
        end
      end
      if (m_ev && out_ready) void'(mq.pop_front());
      exp_drop = m_d; exp_err = m_e;
    end
  end

  // cyc counts completed edges; during a cycle the current cycle index is cyc
  always @(negedge clk) begin
    if (mdl_on) begin
      c_ev = (mq.size() > 0) && (mq[0].vis <= cyc);
      chk("out_valid", out_valid, c_ev);
      if (c_ev && out_valid) chk("out_entry", {out_dllp, out_sop, out_eop, out_data}, mq[0].e);
      chk("pkt_drop", pkt_drop, exp_drop);
      chk("err_unexp", err_unexp, exp_err);
    end
  end

  logic [10:0] cap[$];
  int drop_cnt = 0, err_cnt = 0;
  always @(posedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) cap.push_back({out_dllp, out_sop, out_eop, out_data});
      drop_cnt += pkt_drop;
      err_cnt  += err_unexp;
    end
  end

  bit rdy_rand = 0, rdy_fix = 1;
  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? ($urandom_range(0, 3) != 0) : rdy_fix;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] t, input logic [7:0] d);
    valid_in = 1; type_in = t; data_in = d;
    tick();
    valid_in = 0; type_in = TY_NONE;
  endtask

  task automatic gap();
    if ($urandom_range(0, 4) == 0) begin
      if ($urandom_range(0, 1) == 1) begin valid_in = 1; type_in = TY_NONE; data_in = 8'($urandom); end
      tick();
      valid_in = 0; type_in = TY_NONE;
    end
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && mq.size() > 0; i++) tick();
    if (mq.size() > 0) timeout_fail("drain");
    repeat (3) tick();
  endtask

  task automatic send_pkt(input logic [5:0] st, input int n, input logic [7:0] base, input logic [5:0] en);
    send(st, 8'h00);
    for (int i = 0; i < n; i++) send(TY_DATA, base + 8'(i));
    send(en, 8'h00);
  endtask

  int d0, e0, len, kind;

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1; valid_in = 0; type_in = TY_NONE; data_in = 0; out_ready = 1;
    repeat (2) tick();
    rst = 0;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_pulses", {pkt_drop, err_unexp}, 0);
    tick();

    // Plain TLP
    cap.delete(); d0 = drop_cnt; e0 = err_cnt;
    send(TY_TS, 0); send(TY_DATA, 8'h11); send(TY_DATA, 8'h22); send(TY_DATA, 8'h33); send(TY_TE, 0);
    drain();
    chk("tlp_len", cap.size(), 3);
    chk("tlp_b0", cap[0], 11'h211);
    chk("tlp_b1", cap[1], 11'h022);
    chk("tlp_b2", cap[2], 11'h133);
    chk("tlp_pulses", (drop_cnt - d0) + (err_cnt - e0), 0);

    // Good DLLP, then a 7-byte DLLP
    cap.delete(); d0 = drop_cnt;
    send_pkt(TY_DS, 8, 8'hA0, TY_DE);
    drain();
    chk("dllp_len", cap.size(), 8);
    chk("dllp_first", cap[0], 11'h6A0);
    chk("dllp_last", cap[7], 11'h5A7);
    chk("dllp_mid", cap[3], 11'h4A3);
    cap.delete();
    send_pkt(TY_DS, 7, 8'hB0, TY_DE);
    drain();
    chk("dllp7_len", cap.size(), 0);
    chk("dllp7_drop", drop_cnt - d0, 1);

    // EDB then a good TLP
    cap.delete(); d0 = drop_cnt;
    send_pkt(TY_TS, 5, 8'h60, TY_EDB);
    send(TY_TS, 0); send(TY_DATA, 8'h5A); send(TY_DATA, 8'h5B); send(TY_TE, 0);
    drain();
    chk("edb_drop", drop_cnt - d0, 1);
    chk("edb_len", cap.size(), 2);
    chk("edb_next_b0", cap[0], 11'h25A);
    chk("edb_next_b1", cap[1], 11'h15B);

    // Unexpected data in IDLE, then TLP aborted by a DLLP start
    cap.delete(); d0 = drop_cnt; e0 = err_cnt;
    send(TY_DATA, 8'h99);
    send(TY_TS, 0); send(TY_DATA, 8'h01); send(TY_DATA, 8'h02);
    send_pkt(TY_DS, 8, 8'hC0, TY_DE);
    drain();
    chk("abort_err", err_cnt - e0, 2);
    chk("abort_drop", drop_cnt - d0, 1);
    chk("abort_len", cap.size(), 8);
    chk("abort_first", cap[0], 11'h6C0);

    // Fill: 12-byte TLP held back, 8-byte TLP overflows
    cap.delete(); d0 = drop_cnt; rdy_fix = 0;
    send_pkt(TY_TS, 12, 8'h40, TY_TE);
    send_pkt(TY_TS, 8, 8'h80, TY_TE);
    repeat (4) tick();
    chk("full_drop", drop_cnt - d0, 1);
    chk("full_stalled", cap.size(), 0);
    rdy_fix = 1;
    drain();
    chk("full_len", cap.size(), 12);
    chk("full_first", cap[0], 11'h240);
    chk("full_last", cap[11], 11'h14B);

    // Reset mid-read and mid-packet
    cap.delete(); rdy_fix = 0;
    send_pkt(TY_TS, 4, 8'h10, TY_TE);
    repeat (4) tick();
    chk("pre_rst_valid", out_valid, 1);
    send(TY_TS, 0); send(TY_DATA, 8'hE1); send(TY_DATA, 8'hE2);
    rst = 1; tick(); rst = 0;
    chk("rst_valid", out_valid, 0);
    cap.delete(); rdy_fix = 1;
    send(TY_TS, 0); send(TY_DATA, 8'h77); send(TY_DATA, 8'h88); send(TY_TE, 0);
    drain();
    chk("rst_len", cap.size(), 2);
    chk("rst_b0", cap[0], 11'h277);
    chk("rst_b1", cap[1], 11'h188);

    // Randomized traffic, compared cycle by cycle against the model
    rdy_rand = 1;
    for (int p = 0; p < 120; p++) begin
      for (int w = 0; w < 400 && mq.size() > 4; w++) tick();
      if (mq.size() > 4) timeout_fail("random_backlog");
      gap();
      kind = $urandom_range(0, 7);
      case (kind)
        0, 1: len = $urandom_range(1, 7);
        2:    len = TDLLP;
        3:    len = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 7) : $urandom_range(9, 10);
        4:    len = $urandom_range(0, 5);
        default: len = $urandom_range(0, 4);
      endcase
      if (kind == 6) begin
        case ($urandom_range(0, 3))
          0: send(TY_DATA, 8'($urandom));
          1: send(TY_TE, 0);
          2: send(TY_DE, 0);
          default: send(TY_EDB, 0);
        endcase
      end else begin
        send((kind == 2 || kind == 3 || (kind >= 5 && $urandom_range(0, 1) == 1)) ? TY_DS : TY_TS, 0);
        for (int i = 0; i < len; i++) begin
          gap();
          send(TY_DATA, 8'($urandom));
        end
        gap();
        case (kind)
          0, 1:    send(TY_TE, 0);
          2, 3:    send(TY_DE, 0);
          4:       send(TY_EDB, 0);
          7:       send(($urandom_range(0, 1) == 1) ? TY_DE : TY_TE, 0);
          default: ;
        endcase
      end
    end
    rdy_rand = 0; rdy_fix = 1;
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
